// File: rtl/imem_loader_if.sv
// Byte-stream input and word-write output of the instruction-memory loader.
// The loader takes the slave side; the stream source and memory take the master side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a big-endian byte image into consecutive memory words and holds the
// CPU in reset until the image has been written.
//
// state | meaning
// IDLE  | after reset, waiting for start; CPU held in reset
// LOAD  | accepting bytes and assembling the current word
// WRITE | one-cycle write strobe for the completed word
// DRAIN | capacity exceeded; discarding bytes until in_last
// DONE  | image complete; CPU released until the next start
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_loader_if.slave          bus,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err_partial,
    output logic                  err_overflow
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);

    state_t      state;
    logic [1:0]  bcnt;
    logic [31:0] word_buf;
    logic [31:0] asm_word;
    logic        last_pend;

    assign bus.in_ready = (state == LOAD) || (state == DRAIN);

    // word_buf is cleared per word, so unfilled low bytes of a short final word read as zero
    always_comb begin
        asm_word = word_buf;
        case (bcnt)
            2'd0: asm_word[31:24] = bus.in_data;
            2'd1: asm_word[23:16] = bus.in_data;
            2'd2: asm_word[15:8]  = bus.in_data;
            default: asm_word[7:0] = bus.in_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bcnt          <= 2'd0;
            word_buf      <= 32'd0;
            last_pend     <= 1'b0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            word_count    <= '0;
            err_partial   <= 1'b0;
            err_overflow  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        bcnt         <= 2'd0;
                        word_buf     <= 32'd0;
                        last_pend    <= 1'b0;
                        word_count   <= '0;
                        err_partial  <= 1'b0;
                        err_overflow <= 1'b0;
                        bus.mem_addr <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (bcnt == 2'd3 || bus.in_last) begin
                            bcnt      <= 2'd0;
                            word_buf  <= 32'd0;
                            last_pend <= bus.in_last;
                            if (bcnt != 2'd3) begin
                                err_partial <= 1'b1;
                            end
                            if (word_count == MAX_CNT) begin
                                err_overflow <= 1'b1;
                                if (bus.in_last) begin
                                    state     <= DONE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    cpu_reset <= 1'b0;
                                end else begin
                                    state <= DRAIN;
                                end
                            end else begin
                                state         <= WRITE;
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= word_count[ADDR_WIDTH-1:0];
                                bus.mem_wdata <= asm_word;
                            end
                        end else begin
                            bcnt     <= bcnt + 2'd1;
                            word_buf <= asm_word;
                        end
                    end
                end
                WRITE: begin
                    bus.mem_we <= 1'b0;
                    word_count <= word_count + 1'b1;
                    if (last_pend) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end
                DRAIN: begin
                    if (bus.in_valid && bus.in_last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued as bytes are
// driven and checked when the write strobe appears.
module tb_imem_loader;
    localparam int AW = 10;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cpu_reset, busy, done, err_partial, err_overflow;
    logic [AW:0]   word_count;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .err_partial  (err_partial),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int write_cnt = 0;
    logic [AW+31:0] exp_q[$];

    // scoreboard: every strobe must match the oldest queued {addr, data}
    always @(negedge clk) begin
        if (reset && bus.mem_we) begin
            logic [AW+31:0] e;
            write_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%08h, expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             bus.mem_addr, bus.mem_wdata, e[AW+31:32], e[31:0]);
                end
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write got %b, expected 0", bus.in_ready);
            end
        end
    end

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap, output int waits);
        logic acc;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        waits = 0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) break;
            waits++;
            if (waits > 20) begin
                checks++;
                errors++;
                $display("FAIL byte_accept got no in_ready in 20 cycles, expected acceptance");
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got done=%b, expected 1 within 20 cycles", name, done);
        end
    endtask

    task automatic check_end(input string name, input int exp_wc, input logic ep, input logic eo, input int exp_writes);
        checks++;
        if ({done, busy, cpu_reset} !== 3'b100) begin
            errors++;
            $display("FAIL %s_status got done/busy/cpu_reset=%b, expected 100", name, {done, busy, cpu_reset});
        end
        checks++;
        if (word_count !== (AW+1)'(exp_wc)) begin
            errors++;
            $display("FAIL %s_word_count got %0d, expected %0d", name, word_count, exp_wc);
        end
        checks++;
        if ({err_partial, err_overflow} !== {ep, eo}) begin
            errors++;
            $display("FAIL %s_errs got %b%b, expected %b%b", name, err_partial, err_overflow, ep, eo);
        end
        checks++;
        if (write_cnt !== exp_writes || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes got %0d writes, %0d pending, expected %0d writes", name, write_cnt, exp_q.size(), exp_writes);
        end
    endtask

    task automatic send_image(input logic [7:0] img[$], input int max_gap, output int wait5);
        int w;
        wait5 = 0;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], i == img.size() - 1, (i == 4) ? 0 : $urandom_range(0, max_gap), w);
            if (i == 4) wait5 = w;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.in_ready, bus.mem_we, busy, done, err_partial, err_overflow, cpu_reset} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_ctrl got %b, expected 0000001",
                     {bus.in_ready, bus.mem_we, busy, done, err_partial, err_overflow, cpu_reset});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%0h data=%08h wc=%0d, expected zeros", bus.mem_addr, bus.mem_wdata, word_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] img[$] = '{8'h20, 8'h09, 8'h00, 8'h07, 8'h20, 8'h0a, 8'h00, 8'h02};
        int w5;
        write_cnt = 0;
        do_start();
        expect_write(0, 32'h20090007);
        expect_write(1, 32'h200a0002);
        send_image(img, 0, w5);
        wait_done("basic");
        check_end("basic", 2, 1'b0, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] img[$] = '{8'h20, 8'h09, 8'h00, 8'h07, 8'h20, 8'h0a, 8'h00, 8'h02};
        int w5;
        write_cnt = 0;
        do_start();
        expect_write(0, 32'h20090007);
        expect_write(1, 32'h200a0002);
        send_image(img, 3, w5);
        checks++;
        if (w5 !== 1) begin
            errors++;
            $display("FAIL bp_byte5_wait got %0d cycles, expected 1", w5);
        end
        wait_done("bp");
        check_end("bp", 2, 1'b0, 1'b0, 2);
    endtask

    task automatic test_partial();
        logic [7:0] img[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        int w5;
        write_cnt = 0;
        do_start();
        expect_write(0, 32'h11223344);
        expect_write(1, 32'hAABB0000);
        send_image(img, 1, w5);
        wait_done("partial");
        check_end("partial", 2, 1'b1, 1'b0, 2);
    endtask

    task automatic test_reload();
        logic [7:0] img[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int w5;
        write_cnt = 0;
        do_start();
        checks++;
        if ({cpu_reset, done, busy, err_partial, err_overflow, word_count} !== {5'b10100, (AW+1)'(0)}) begin
            errors++;
            $display("FAIL reload_clear got cr/done/busy/ep/eo=%b wc=%0d, expected 10100 wc=0",
                     {cpu_reset, done, busy, err_partial, err_overflow}, word_count);
        end
        expect_write(0, 32'h01020304);
        send_image(img, 2, w5);
        wait_done("reload");
        check_end("reload", 1, 1'b0, 1'b0, 1);
    endtask

    task automatic test_overflow(input int nbytes);
        logic [7:0] img[$];
        int w5;
        write_cnt = 0;
        for (int i = 0; i < nbytes; i++) img.push_back(8'(8'h30 + i));
        do_start();
        expect_write(0, 32'h30313233);
        expect_write(1, 32'h34353637);
        send_image(img, 1, w5);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ovf%0d_done_now got %b, expected 1 right after last byte", nbytes, done);
        end
        checks++;
        if (err_overflow !== 1'b1 || word_count !== (AW+1)'(2) || write_cnt !== 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf%0d got eo=%b wc=%0d writes=%0d, expected eo=1 wc=2 writes=2",
                     nbytes, err_overflow, word_count, write_cnt);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] img[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        int w;
        write_cnt = 0;
        do_start();
        send_byte(8'h55, 1'b0, 0, w);
        send_byte(8'h66, 1'b0, 0, w);
        reset = 1'b0;
        #2;
        test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_start();
        expect_write(0, 32'hDEADBEEF);
        send_image(img, 1, w);
        wait_done("rstmid");
        check_end("rstmid", 1, 1'b0, 1'b0, 1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        #12;
        test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial();
        test_reload();
        test_overflow(12);
        test_overflow(14);
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
